// File: rtl/divider_if.sv
// Handshake and result bus of the multi-cycle divider.
// The sequencer drives from the master side and the divider sits on the slave side.
interface divider_if #(parameter int WIDTH = 8);
  logic             enable;
  logic             start;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output enable, start, op1, op2,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  enable, start, op1, op2,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/divider.sv
// Restoring shift-and-subtract divider, one quotient bit per enabled clock.
// Define DIVIDER_SIGNED_EN for two's complement operands; the default build is unsigned.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module divider #(
  parameter int WIDTH = `DATA_WIDTH
) (
  input  logic     clock,
  input  logic     reset,
  divider_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dvs, op1_q;
  logic [WIDTH:0]   pr;
  logic             sgn1, sgn2;
  logic             done_q, dz_q;
  logic [WIDTH-1:0] quo_q, rem_q;

  logic [WIDTH-1:0] mag1, mag2;
  logic             s1, s2;
  logic [2*WIDTH:0] sh;
  logic [WIDTH+1:0] trial;
  logic             ge;
  logic [WIDTH:0]   pr_nxt;
  logic [WIDTH-1:0] dvd_nxt, q_fix, r_fix;

  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    s1   = bus.op1[WIDTH-1];
    s2   = bus.op2[WIDTH-1];
    mag1 = s1 ? -bus.op1 : bus.op1;
    mag2 = s2 ? -bus.op2 : bus.op2;
`else
    s1   = 1'b0;
    s2   = 1'b0;
    mag1 = bus.op1;
    mag2 = bus.op2;
`endif
  end

  // Trial subtract is one bit wider than pr so its top bit is the borrow.
  always_comb begin
    sh      = {pr, dvd} << 1;
    trial   = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, dvs};
    ge      = ~trial[WIDTH+1];
    pr_nxt  = ge ? trial[WIDTH:0] : sh[2*WIDTH:WIDTH];
    dvd_nxt = {sh[WIDTH-1:1], ge};
  end

  always_comb begin
    q_fix = (sgn1 ^ sgn2) ? -dvd : dvd;
    r_fix = sgn1 ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      op1_q  <= '0;
      pr     <= '0;
      sgn1   <= 1'b0;
      sgn2   <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else if (bus.enable) begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          dvd   <= mag1;
          dvs   <= mag2;
          sgn1  <= s1;
          sgn2  <= s2;
          op1_q <= bus.op1;
          pr    <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          pr  <= pr_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          // A zero divisor runs the full iteration count; only the result is overridden.
          if (dvs == '0) begin
            quo_q <= '1;
            rem_q <= op1_q;
            dz_q  <= 1'b1;
          end else begin
            quo_q <= q_fix;
            rem_q <= r_fix;
            dz_q  <= 1'b0;
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == RUN) || (state == FIX);
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_divider.sv
// Divider bench: directed cases with literal results plus randomized traffic,
// all checked every cycle against a transaction-level arithmetic model.
module tb_divider;
  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  divider_if #(.WIDTH(W)) dif();
  divider #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(dif));

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: int division truncates toward zero and % follows the dividend.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
    int ia, ib;
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1;
      return;
    end
`ifdef DIVIDER_SIGNED_EN
    ia = int'($signed(a));
    ib = int'($signed(b));
`else
    ia = int'({24'd0, a});
    ib = int'({24'd0, b});
`endif
    q  = W'(ia / ib);
    r  = W'(ia % ib);
    dz = 1'b0;
  endfunction

  // Transaction model: an accepted request completes after W+1 enabled edges.
  bit           m_busy = 0, m_done = 0, m_dz = 0, p_dz;
  int           m_left = 0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q, p_r;

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_left = 0; m_q = '0; m_r = '0; m_dz = 0;
    end else if (dif.enable) begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end else if (dif.start) begin
        ref_div(dif.op1, dif.op2, p_q, p_r, p_dz);
        m_busy = 1;
        m_left = W + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("busy", 32'(dif.busy), 32'(m_busy));
      check("done", 32'(dif.done), 32'(m_done));
      check("quotient", 32'(dif.quotient), 32'(m_q));
      check("remainder", 32'(dif.remainder), 32'(m_r));
      check("div_zero", 32'(dif.div_zero), 32'(m_dz));
    end
  end

  // Start one division at a negedge and return at the negedge where done is visible.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int stall_at,
                        input bit glitch, output int lat, output int bcnt);
    dif.op1 = a; dif.op2 = b; dif.start = 1'b1; dif.enable = 1'b1;
    @(negedge clock);
    dif.start = 1'b0;
    lat  = 0;
    bcnt = dif.busy ? 1 : 0;
    while (!dif.done && lat < 40) begin
      dif.enable = !(lat >= stall_at && lat < stall_at + 3);
      if (glitch && lat == 2) begin
        dif.start = 1'b1; dif.op1 = 8'd1; dif.op2 = 8'd1;
      end else dif.start = 1'b0;
      @(negedge clock);
      lat++;
      if (dif.busy) bcnt++;
    end
    dif.enable = 1'b1;
    dif.start  = 1'b0;
  endtask

`ifdef DIVIDER_SIGNED_EN
  localparam logic [15:0] E_N100_7  = 16'hF2FE;
  localparam logic [15:0] E_100_N7  = 16'hF202;
  localparam logic [15:0] E_N100_N7 = 16'h0EFE;
  localparam logic [15:0] E_MIN_N1  = 16'h8000;
`else
  localparam logic [15:0] E_N100_7  = 16'h1602;
  localparam logic [15:0] E_100_N7  = 16'h0064;
  localparam logic [15:0] E_N100_N7 = 16'h009C;
  localparam logic [15:0] E_MIN_N1  = 16'h0080;
`endif

  initial begin
    int lat, bcnt, dcnt;
    dif.enable = 1'b1; dif.start = 1'b0; dif.op1 = '0; dif.op2 = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 32'(dif.busy), 32'd0);
    check("rst_done", 32'(dif.done), 32'd0);
    check("rst_quotient", 32'(dif.quotient), 32'd0);
    check("rst_remainder", 32'(dif.remainder), 32'd0);
    check("rst_div_zero", 32'(dif.div_zero), 32'd0);

    do_div(8'd100, 8'd7, 1000, 0, lat, bcnt);
    check("lat_100_7", 32'(lat), 32'd9);
    check("busy_cycles_100_7", 32'(bcnt), 32'd9);
    check("q_100_7", 32'(dif.quotient), 32'd14);
    check("r_100_7", 32'(dif.remainder), 32'd2);
    check("dz_100_7", 32'(dif.div_zero), 32'd0);

    do_div(8'h9C, 8'd7, 1000, 0, lat, bcnt);
    check("qr_n100_7", 32'({dif.quotient, dif.remainder}), 32'(E_N100_7));
    do_div(8'd100, 8'hF9, 1000, 0, lat, bcnt);
    check("qr_100_n7", 32'({dif.quotient, dif.remainder}), 32'(E_100_N7));
    do_div(8'h9C, 8'hF9, 1000, 0, lat, bcnt);
    check("qr_n100_n7", 32'({dif.quotient, dif.remainder}), 32'(E_N100_N7));

    do_div(8'd7, 8'd0, 1000, 0, lat, bcnt);
    check("lat_div0", 32'(lat), 32'd9);
    check("q_div0", 32'(dif.quotient), 32'hFF);
    check("r_div0", 32'(dif.remainder), 32'd7);
    check("dz_div0", 32'(dif.div_zero), 32'd1);
    do_div(8'd9, 8'd3, 1000, 0, lat, bcnt);
    check("qrz_9_3", 32'({dif.div_zero, dif.quotient, dif.remainder}), 32'h00300);

    do_div(8'h80, 8'hFF, 1000, 0, lat, bcnt);
    check("qr_min_n1", 32'({dif.quotient, dif.remainder}), 32'(E_MIN_N1));
    do_div(8'd127, 8'd1, 1000, 0, lat, bcnt);
    check("lat_b2b", 32'(lat), 32'd9);
    check("q_b2b", 32'(dif.quotient), 32'd127);

    do_div(8'd50, 8'd5, 4, 1, lat, bcnt);
    check("lat_stall", 32'(lat), 32'd12);
    check("q_stall", 32'(dif.quotient), 32'd10);
    check("r_stall", 32'(dif.remainder), 32'd0);

    // Hold done through a disabled edge: it must survive until the next enabled edge.
    dif.enable = 1'b0;
    @(negedge clock);
    check("done_held", 32'(dif.done), 32'd1);
    dif.enable = 1'b1;

    dif.op1 = 8'd50; dif.op2 = 8'd5; dif.start = 1'b1;
    @(negedge clock);
    dif.start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rstmid_busy", 32'(dif.busy), 32'd0);
    check("rstmid_q", 32'(dif.quotient), 32'd0);
    check("rstmid_r", 32'(dif.remainder), 32'd0);
    check("rstmid_dz", 32'(dif.div_zero), 32'd0);
    dcnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (dif.done) dcnt++;
    end
    check("rstmid_no_done", 32'(dcnt), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      dif.enable = ($urandom_range(0, 3) != 0);
      dif.start  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       dif.op1 = 8'h80;
        1:       dif.op1 = 8'h7F;
        default: dif.op1 = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       dif.op2 = 8'h00;
        1:       dif.op2 = 8'hFF;
        2:       dif.op2 = 8'h01;
        default: dif.op2 = W'($urandom);
      endcase
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clock);
    end
    reset = 1'b0;
    dif.start = 1'b0;
    dif.enable = 1'b1;
    repeat (12) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
